// File: rtl/input_debounce_jdl25175_if.sv
// Signal bundle between the raw switch lines and the debounce stage's clean-code consumers.
// The master drives raw_in; the debouncer sits on the slave side.
interface input_debounce_jdl25175_if;
  logic [1:0] raw_in;
  logic [1:0] clean_out;
  logic       changed;
  logic       busy;

  modport master (
    output raw_in,
    input  clean_out,
    input  changed,
    input  busy
  );

  modport slave (
    input  raw_in,
    output clean_out,
    output changed,
    output busy
  );
endinterface

// File: rtl/input_debounce_jdl25175.sv
// Two-flop synchronizer followed by a vector debouncer: a new 2-bit code must be seen
// DEBOUNCE_CYCLES consecutive times before it replaces clean_out, which then pulses changed.
module input_debounce_jdl25175 #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                         clock,
  input  logic                         init,
  input_debounce_jdl25175_if.slave     bus
);

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       candidate_q, candidate_d;
  logic [1:0]       clean_q, clean_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             changed_q, changed_d;

  // init wins over everything, including an acceptance falling on the same edge
  always_ff @(posedge clock) begin
    if (init) begin
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      candidate_q <= 2'b00;
      clean_q     <= 2'b00;
      count_q     <= '0;
      changed_q   <= 1'b0;
      state_q     <= STABLE;
    end else begin
      sync1_q     <= bus.raw_in;
      sync2_q     <= sync1_q;
      candidate_q <= candidate_d;
      clean_q     <= clean_d;
      count_q     <= count_d;
      changed_q   <= changed_d;
      state_q     <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    candidate_d = candidate_q;
    clean_d     = clean_q;
    count_d     = count_q;
    changed_d   = 1'b0;

    case (state_q)
      STABLE: begin
        if (sync2_q != clean_q) begin
          candidate_d = sync2_q;
          count_d     = CNT_W'(1);
          state_d     = SETTLE;
        end else begin
          count_d = '0;
        end
      end

      // Returning to the held code cancels; any other new code restarts qualification
      SETTLE: begin
        if (sync2_q == clean_q) begin
          count_d = '0;
          state_d = STABLE;
        end else if (sync2_q != candidate_q) begin
          candidate_d = sync2_q;
          count_d     = CNT_W'(1);
        end else if (count_q == LAST_COUNT) begin
          clean_d   = candidate_q;
          changed_d = 1'b1;
          count_d   = '0;
          state_d   = STABLE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end

      default: begin
        count_d = '0;
        state_d = STABLE;
      end
    endcase
  end

  assign bus.clean_out = clean_q;
  assign bus.changed   = changed_q;
  assign bus.busy      = (state_q == SETTLE);

endmodule
